// File: rtl/led_pwm_pkg.sv
`default_nettype none
// ============================================================================
// led_pwm_pkg : register map and default sizing for the LED PWM slot
// Rev 1.0
// ============================================================================
package led_pwm_pkg;

    localparam int DEF_N_CH    = 4;
    localparam int DEF_DUTY_W  = 8;
    localparam int DEF_PRESC_W = 16;

    localparam logic [4:0] ADDR_CTRL   = 5'd0;
    localparam logic [4:0] ADDR_PRESC  = 5'd1;
    localparam logic [4:0] ADDR_DUTY0  = 5'd2;
    localparam logic [4:0] ADDR_STATUS = 5'd6;

    localparam logic [DEF_DUTY_W-1:0] DUTY_FULL = '1;

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// pwm_timebase : prescaler tick generator and free-running PWM phase counter
// Rev 1.0
// ============================================================================
module pwm_timebase
    import led_pwm_pkg::*;
#(
    parameter int DUTY_W  = DEF_DUTY_W,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick,
    output logic [DUTY_W-1:0]  pwm_cnt,
    output logic               wrap
);

    logic [PRESC_W-1:0] presc_cnt;

    // >= rather than == so a lowered PRESC ticks at once instead of wrapping the prescaler
    assign tick = en && (presc_cnt >= presc);
    assign wrap = tick && (pwm_cnt == {DUTY_W{1'b1}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (!en) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + 1'b1;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pwm_slot.sv
`default_nettype none
// ============================================================================
// led_pwm_slot : slot-bus core gating blinker LED states with per-channel PWM
// Rev 1.0
// ============================================================================
module led_pwm_slot
    import led_pwm_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int DUTY_W  = DEF_DUTY_W,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cs,
    input  logic            read,
    input  logic            write,
    input  logic [4:0]      addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    input  logic [N_CH-1:0] led_in,
    output logic [N_CH-1:0] led_out
);

    logic               en;
    logic [PRESC_W-1:0] presc;
    logic [DUTY_W-1:0]  pend_duty [N_CH];
    logic [DUTY_W-1:0]  act_duty  [N_CH];
    logic               wrap_flag;
    logic               tick;
    logic               wrap;
    logic [DUTY_W-1:0]  pwm_cnt;
    logic [N_CH-1:0]    gate;
    logic               wr_en;
    logic               unused_ok;

    assign wr_en     = cs & write;
    assign unused_ok = &{1'b0, read, tick, wr_data[31:PRESC_W]};

    pwm_timebase #(
        .DUTY_W  (DUTY_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .presc   (presc),
        .tick    (tick),
        .pwm_cnt (pwm_cnt),
        .wrap    (wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en        <= 1'b0;
            presc     <= '0;
            wrap_flag <= 1'b0;
        end else begin
            if (wr_en && addr == ADDR_CTRL)  en    <= wr_data[0];
            if (wr_en && addr == ADDR_PRESC) presc <= wr_data[PRESC_W-1:0];
            // a wrap in the same cycle as a clear-write keeps the flag set
            if (wrap)
                wrap_flag <= 1'b1;
            else if (wr_en && addr == ADDR_STATUS)
                wrap_flag <= 1'b0;
        end
    end

    // active duty only reloads at period boundaries so a period is never torn
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                pend_duty[i] <= '1;
                act_duty[i]  <= '1;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_en && addr == ADDR_DUTY0 + 5'(i))
                    pend_duty[i] <= wr_data[DUTY_W-1:0];
                if (!en || wrap)
                    act_duty[i] <= pend_duty[i];
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign gate[i] = (act_duty[i] == {DUTY_W{1'b1}}) || (pwm_cnt < act_duty[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            led_out <= '0;
        else
            led_out <= en ? (led_in & gate) : led_in;
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_CTRL:   rd_data[0]         = en;
            ADDR_PRESC:  rd_data[PRESC_W-1:0] = presc;
            ADDR_STATUS: begin
                rd_data[DUTY_W-1:0] = pwm_cnt;
                rd_data[DUTY_W]     = wrap_flag;
            end
            default: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (addr == ADDR_DUTY0 + 5'(i))
                        rd_data[DUTY_W-1:0] = pend_duty[i];
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_slot.sv
`default_nettype none
// ============================================================================
// tb_led_pwm_slot : self-checking bench for the LED PWM slot core
// Rev 1.0
// ============================================================================
module tb_led_pwm_slot;
    import led_pwm_pkg::*;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        cs      = 1'b0;
    logic        read    = 1'b0;
    logic        write   = 1'b0;
    logic [4:0]  addr    = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic [3:0]  led_in  = '0;
    logic [3:0]  led_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sb_q[$];

    typedef struct packed {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [12];

    always #5 clk = ~clk;

    led_pwm_slot u_dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .led_in  (led_in),
        .led_out (led_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [31:0] act);
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", name, act);
        end else begin
            check(name, act, sb_q.pop_front());
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
        cs      = 1'b0;
        write   = 1'b0;
        wr_data = '0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        addr = a;
        read = 1'b1;
        #1;
        d    = rd_data;
        read = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] v;
        sb_q.push_back(exp);
        rd(a, v);
        sb_check(name, v);
    endtask

    task automatic measure(input int n, output int c0, output int c1, output int c2,
                           output int c3, output int fl0);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; fl0 = -1;
        for (int k = 0; k < n; k++) begin
            cyc(1);
            c0 += int'(led_out[0]);
            c1 += int'(led_out[1]);
            c2 += int'(led_out[2]);
            c3 += int'(led_out[3]);
            if (fl0 < 0 && led_out[0] == 1'b0) fl0 = k;
        end
    endtask

    task automatic wait_pwm(input logic [7:0] t, input string name);
        logic [31:0] v;
        bit found;
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            rd(ADDR_STATUS, v);
            if (v[7:0] == t) found = 1'b1;
            else cyc(1);
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: pwm_cnt never reached %0d", name, t);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, c3, fl0;
        logic [31:0] v;

        vecs[0]  = '{1'b1, ADDR_PRESC,  32'h1234_5678, 32'h0000_5678};
        vecs[1]  = '{1'b1, ADDR_DUTY0,  32'h0000_ABCD, 32'h0000_00CD};
        vecs[2]  = '{1'b1, 5'd3,        32'h0000_0011, 32'h0000_0011};
        vecs[3]  = '{1'b1, 5'd4,        32'h0000_0022, 32'h0000_0022};
        vecs[4]  = '{1'b1, 5'd5,        32'h0000_0133, 32'h0000_0033};
        vecs[5]  = '{1'b0, ADDR_DUTY0,  32'h0,         32'h0000_00CD};
        vecs[6]  = '{1'b1, 5'd7,        32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{1'b0, 5'd31,       32'h0,         32'h0};
        vecs[8]  = '{1'b1, ADDR_CTRL,   32'hFFFF_FFFE, 32'h0};
        vecs[9]  = '{1'b1, ADDR_STATUS, 32'h0000_FFFF, 32'h0};
        vecs[10] = '{1'b1, ADDR_PRESC,  32'h0,         32'h0};
        vecs[11] = '{1'b0, 5'd5,        32'h0,         32'h0000_0033};

        // reset held from time zero
        led_in = 4'hF;
        cyc(3);
        check("reset_led_out", 32'(led_out), 32'h0);
        rst = 1'b1;
        cyc(1);
        rd_check("reset_ctrl",   ADDR_CTRL,   32'h0);
        rd_check("reset_duty0",  ADDR_DUTY0,  32'hFF);
        rd_check("reset_status", ADDR_STATUS, 32'h0);
        rd_check("reset_presc",  ADDR_PRESC,  32'h0);

        // register map vectors
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
            rd_check($sformatf("regvec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // write without cs is ignored
        cs = 1'b0; write = 1'b1; addr = ADDR_DUTY0; wr_data = 32'h55;
        cyc(1);
        write = 1'b0;
        rd_check("write_no_cs", ADDR_DUTY0, 32'hCD);

        // pass-through while disabled
        led_in = 4'b1010;
        sb_q.push_back(32'(4'b1010));
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            sb_check($sformatf("passthru%0d", k), 32'(led_out));
            led_in = led_in ^ 4'b0001;
            sb_q.push_back(32'(led_in));
        end
        cyc(1);
        sb_check("passthru_last", 32'(led_out));

        // duty ratio, PRESC=0
        wr(ADDR_DUTY0, 32'd64);
        wr(5'd3, 32'd0);
        wr(5'd4, 32'hFF);
        wr(5'd5, 32'd128);
        wr(ADDR_PRESC, 32'd0);
        led_in = 4'hF;
        wr(ADDR_CTRL, 32'd1);
        sb_q.push_back(32'd64);
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd256);
        sb_q.push_back(32'd128);
        sb_q.push_back(32'd64);
        measure(256, c0, c1, c2, c3, fl0);
        sb_check("ratio_ch0_duty64",  32'(c0));
        sb_check("ratio_ch1_duty0",   32'(c1));
        sb_check("ratio_ch2_dutyff",  32'(c2));
        sb_check("ratio_ch3_duty128", 32'(c3));
        sb_check("ratio_ch0_first_off", 32'(fl0));

        // wrap flag set, clear, clear-on-wrap
        rd_check("status_after_period", ADDR_STATUS, 32'h100);
        wr(ADDR_STATUS, 32'h0);
        rd_check("status_cleared", ADDR_STATUS, 32'h001);
        wait_pwm(8'd255, "wait_wrap_clear");
        wr(ADDR_STATUS, 32'h0);
        rd_check("status_clear_on_wrap", ADDR_STATUS, 32'h100);

        // duty shadowing: mid-period write
        wait_pwm(8'd10, "wait_pwm10");
        wr(ADDR_DUTY0, 32'd128);
        sb_q.push_back(32'd53);
        measure(245, c0, c1, c2, c3, fl0);
        sb_check("shadow_rest_of_period", 32'(c0));
        sb_q.push_back(32'd128);
        measure(256, c0, c1, c2, c3, fl0);
        sb_check("shadow_next_period", 32'(c0));

        // duty write landing on the wrap tick
        wait_pwm(8'd255, "wait_wrap_duty");
        wr(ADDR_DUTY0, 32'd32);
        sb_q.push_back(32'd128);
        measure(256, c0, c1, c2, c3, fl0);
        sb_check("wrapwrite_old_duty", 32'(c0));
        sb_q.push_back(32'd32);
        measure(256, c0, c1, c2, c3, fl0);
        sb_check("wrapwrite_new_duty", 32'(c0));

        // prescaler = 3, duty 2
        wr(ADDR_CTRL, 32'd0);
        wr(ADDR_DUTY0, 32'd2);
        wr(ADDR_PRESC, 32'd3);
        wr(ADDR_CTRL, 32'd1);
        sb_q.push_back(32'd8);
        sb_q.push_back(32'd8);
        sb_q.push_back(32'd1024);
        measure(1024, c0, c1, c2, c3, fl0);
        sb_check("presc_ch0_on_count", 32'(c0));
        sb_check("presc_ch0_first_off", 32'(fl0));
        sb_check("presc_ch2_on_count", 32'(c2));

        // lowering PRESC below presc_cnt (presc_cnt reaches 3 on this write's edge)
        cyc(2);
        wr(ADDR_PRESC, 32'd1);
        rd(ADDR_STATUS, v);
        check("presc_low_pwm0", v & 32'hFF, 32'd0);
        cyc(1);
        rd(ADDR_STATUS, v);
        check("presc_low_immediate_tick", v & 32'hFF, 32'd1);
        cyc(1);
        rd(ADDR_STATUS, v);
        check("presc_low_hold", v & 32'hFF, 32'd1);
        cyc(1);
        rd(ADDR_STATUS, v);
        check("presc_low_tick2", v & 32'hFF, 32'd2);
        cyc(2);
        rd(ADDR_STATUS, v);
        check("presc_low_tick3", v & 32'hFF, 32'd3);

        // disable: counters to 0, flag held
        wr(ADDR_CTRL, 32'd0);
        cyc(3);
        rd_check("disabled_status", ADDR_STATUS, 32'h100);

        // asynchronous reset mid-operation
        wr(ADDR_CTRL, 32'd1);
        cyc(5);
        check("pre_reset_ch2_on", 32'(led_out[2]), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_led_out", 32'(led_out), 32'h0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rd_check("post_reset_ctrl",   ADDR_CTRL,   32'h0);
        rd_check("post_reset_duty0",  ADDR_DUTY0,  32'hFF);
        rd_check("post_reset_status", ADDR_STATUS, 32'h0);
        rd_check("post_reset_presc",  ADDR_PRESC,  32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
